spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Sequences and shares one 8-bit SPI master among NUM_REQ requesters using round-robin arbitration.
- Per granted request it:
  - latches the requester's byte, direction and clock divider;
  - drives the master's start/write_enable/data/clock_div;
  - tracks the master's done handshake;
  - returns the received byte, or a timeout error, to the owner.
- Sits between the SPI master and the system-side clients.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1023, max clock cycles spent in START or BUSY before abort (1..65535).
- TW, 16, timeout counter width (must hold TIMEOUT).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester transaction request, level.
- req_we  in  NUM_REQ  per-requester direction, copied to master write_enable (1 = receive, 0 = transmit).
- req_data  in  8*NUM_REQ  per-requester TX byte; requester i uses bits [8i+7:8i].
- req_div  in  2*NUM_REQ  per-requester clock_div code; requester i uses bits [2i+1:2i].
- gnt  out  NUM_REQ  one-hot grant pulse, 1 cycle, in the cycle operands are latched.
- rsp_valid  out  NUM_REQ  one-hot completion pulse, 1 cycle.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort.
- rsp_data  out  8  received byte; valid while rsp_valid.
- busy  out  1  high from grant through the response cycle.
- m_start  out  1  to master start.
- m_write_enable  out  1  to master write_enable.
- m_data_tx  out  8  to master dataToTransmit.
- m_clock_div  out  2  to master clock_div.
- m_done  in  1  from master done (1 when idle).
- m_data_rx  in  8  from master dataRecieved.

Behaviour:
- Reset (async, any state):
  - state=IDLE, rr_ptr=NUM_REQ-1.
  - All outputs 0: gnt, rsp_valid, rsp_err, rsp_data, busy, m_start, m_write_enable, m_data_tx, m_clock_div.
  - Timeout counter cleared.
- Reset mid-transaction drops m_start the same instant. No response is issued for the aborted request.
- States:
  - IDLE:
    - If any req bit is set, select the first set bit searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
    - Registered outputs in the same cycle: gnt one-hot pulse, owner index, rr_ptr=owner.
    - Latch operands into registers: m_data_tx, m_write_enable, m_clock_div.
    - busy=1; go to START.
  - START:
    - m_start=1.
    - If m_done==0, go to BUSY.
    - If the counter reaches TIMEOUT, go to RESP with err=1.
  - BUSY:
    - m_start=0.
    - If m_done==1, capture rsp_data<=m_data_rx if the latched we==1, else 0x00; go to RESP.
    - If the counter reaches TIMEOUT, go to RESP with err=1 and rsp_data=0x00.
  - RESP:
    - rsp_valid[owner]=1 and rsp_err for exactly 1 cycle.
    - Go to GAP.
  - GAP:
    - 1 idle cycle so the master returns to idle; busy=0 at exit.
    - Go to IDLE.
- Timeout counter:
  - Cleared on entry to START and again on entry to BUSY.
  - Increments each cycle spent in either state.
  - Saturating compare, ==TIMEOUT.
- Operands are latched only at grant. Later changes to req_data/req_we/req_div are ignored until the next grant.
- Back-to-back: minimum of 4 arbiter cycles of overhead per transaction (IDLE, START≥1, RESP, GAP), plus master time.
- Requester i deasserting req after its gnt does not cancel: the transaction completes and rsp_valid[i] still pulses.
- Requester deasserting req before grant is simply not selected.
- Requester owning the previous grant is lowest priority next round. A requester holding req continuously with others idle is re-granted every transaction.
- Simultaneous requests are resolved purely by rr_ptr order. No starvation: worst-case wait is NUM_REQ-1 transactions.
- Unused/out-of-range divider codes (2'b11) are passed through unchanged. The master defaults them to divide-by-2.
- gnt and rsp_valid are never both asserted in the same cycle.

Test Plan:
- Single request: req[1]=1, we=0, data=0xA5, div=2'b01 → gnt=4'b0010 one cycle. Then m_data_tx=0xA5 and m_clock_div=01. m_start high until m_done falls. rsp_valid=4'b0010, rsp_err=0, rsp_data=0x00.
- Receive: req[0], we=1; the master model returns m_data_rx=0x3C with done rising → rsp_valid[0]=1, rsp_data=0x3C, m_write_enable=1 throughout.
- Round-robin: req=4'b1111 held for 5 transactions from reset → grant order 0,1,2,3,0. Each owner gets exactly one rsp_valid.
- Timeout in START: m_done stuck at 1, TIMEOUT=8 → m_start high 8 cycles then drops. rsp_valid[owner]=1, rsp_err=1, rsp_data=0x00. The arbiter returns to IDLE and grants the next request.
- Reset mid-BUSY: assert reset while busy=1 → all outputs 0 immediately, no rsp_valid. After release, a pending req[2] is granted first.
- Operand stability: change req_data[0] from 0x11 to 0x22 one cycle after gnt[0] → m_data_tx stays 0x11 for the whole transaction.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one 8-bit SPI master among NUM_REQ requesters.
// A round-robin grant latches the winner's byte, direction and divider.
// The arbiter then runs the master's start/done handshake and returns
// either the received byte or a timeout error to the owning requester.

module spi_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [2*NUM_REQ-1:0]   req_div,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic                   rsp_err,
  output logic [7:0]             rsp_data,
  output logic                   busy,
  output logic                   m_start,
  output logic                   m_write_enable,
  output logic [7:0]             m_data_tx,
  output logic [1:0]             m_clock_div,
  input  logic                   m_done,
  input  logic [7:0]             m_data_rx
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BUSY, S_RESP, S_GAP} state_t;

  state_t            state;
  state_t            next_state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic              err_q;
  logic [TW-1:0]     tmo_cnt;
  logic              tmo_hit;
  logic [NUM_REQ-1:0] owner_onehot;

  // The current cycle is the TIMEOUT-th one spent in START or BUSY.
  assign tmo_hit      = (tmo_cnt == TW'(TIMEOUT - 1));
  assign owner_onehot = NUM_REQ'(1) << owner;

  // Round-robin pick: the first set request after rr_ptr, wrapping around.
  always_comb begin
    logic [IW-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; done takes precedence over a coincident timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (pick_valid) next_state = S_START;
      S_START: begin
        if (!m_done)      next_state = S_BUSY;
        else if (tmo_hit) next_state = S_RESP;
      end
      S_BUSY:  if (m_done || tmo_hit) next_state = S_RESP;
      S_RESP:  next_state = S_GAP;
      S_GAP:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from the state; reset drops m_start immediately.
  always_comb begin
    m_start   = (state == S_START);
    busy      = (state == S_START) || (state == S_BUSY) || (state == S_RESP);
    rsp_valid = '0;
    rsp_err   = 1'b0;
    if (state == S_RESP) begin
      rsp_valid = owner_onehot;
      rsp_err   = err_q;
    end
  end

  // Timeout counter: cleared on entry to START and BUSY, saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if ((state != next_state) &&
                 ((next_state == S_START) || (next_state == S_BUSY))) begin
      tmo_cnt <= '0;
    end else if (((state == S_START) || (state == S_BUSY)) && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Grant, operand latching and response capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt            <= '0;
      owner          <= '0;
      rr_ptr         <= IW'(NUM_REQ - 1);
      m_data_tx      <= '0;
      m_write_enable <= 1'b0;
      m_clock_div    <= '0;
      rsp_data       <= '0;
      err_q          <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt            <= NUM_REQ'(1) << pick_idx;
            owner          <= pick_idx;
            rr_ptr         <= pick_idx;
            m_data_tx      <= req_data[pick_idx*8 +: 8];
            m_write_enable <= req_we[pick_idx];
            m_clock_div    <= req_div[pick_idx*2 +: 2];
            rsp_data       <= '0;
            err_q          <= 1'b0;
          end
        end
        S_START: begin
          if (m_done && tmo_hit) begin
            err_q    <= 1'b1;
            rsp_data <= '0;
          end
        end
        S_BUSY: begin
          if (m_done) begin
            rsp_data <= m_write_enable ? m_data_rx : 8'h00;
            err_q    <= 1'b0;
          end else if (tmo_hit) begin
            err_q    <= 1'b1;
            rsp_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed self-checking bench for spi_txn_arbiter,
// with a small behavioural SPI master answering the start/done handshake.

module tb_spi_txn_arbiter;

  localparam int NR  = 4;
  localparam int TMO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [NR-1:0] req, req_we;
  logic [8*NR-1:0] req_data;
  logic [2*NR-1:0] req_div;
  logic [NR-1:0] gnt, rsp_valid;
  logic          rsp_err, busy, m_start, m_write_enable, m_done;
  logic [7:0]    rsp_data, m_data_tx, m_data_rx;
  logic [1:0]    m_clock_div;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;
  int model_mode;
  int model_latency;
  logic [7:0] model_rx;

  spi_txn_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO), .TW(16)) dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we),
    .req_data(req_data), .req_div(req_div), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .busy(busy), .m_start(m_start), .m_write_enable(m_write_enable),
    .m_data_tx(m_data_tx), .m_clock_div(m_clock_div), .m_done(m_done),
    .m_data_rx(m_data_rx)
  );

  always #5 clock = ~clock;

  // Grant and completion pulses must never coincide.
  always @(negedge clock) begin
    if (!reset && (|gnt) && (|rsp_valid)) overlap++;
  end

  // Master model: mode 1 drops done on start, raises it after a latency;
  // mode 0 keeps done stuck high so the arbiter times out in START.
  initial begin
    m_done    = 1'b1;
    m_data_rx = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset && m_start && m_done && model_mode == 1) begin
        m_done = 1'b0;
        repeat (model_latency) @(negedge clock);
        m_data_rx = model_rx;
        m_done    = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic we,
                               input logic [7:0] data, input logic [1:0] div);
    req_we[idx]          = we;
    req_data[idx*8 +: 8] = data;
    req_div[idx*2 +: 2]  = div;
    req[idx]             = 1'b1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic waitGrant(output logic [NR-1:0] g);
    int n = 0;
    while (gnt == '0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    g = gnt;
  endtask

  task automatic waitResponse(output logic [NR-1:0] v);
    int n = 0;
    while (rsp_valid == '0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    v = rsp_valid;
  endtask

  // Bound the whole run so a stuck design still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NR-1:0] g, v, rsp_seen;
    logic [7:0]    bad;
    logic [7:0]    rr_bytes [4];
    int            n, e;

    rr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1; req = '0; req_we = '0; req_data = '0; req_div = '0;
    model_mode = 1; model_latency = 3; model_rx = 8'hEE;
    repeat (3) @(negedge clock);
    checkOutput("reset_outputs", {gnt, rsp_valid, rsp_err, rsp_data, busy,
                m_start, m_write_enable, m_data_tx, m_clock_div}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Single transmit; rx data must be masked because we=0.
    applyStimulus(1, 1'b0, 8'hA5, 2'b01);
    waitGrant(g);
    checkOutput("single_gnt", g, 32'h2);
    checkOutput("single_tx", m_data_tx, 32'hA5);
    checkOutput("single_div", m_clock_div, 32'h1);
    checkOutput("single_start", m_start, 32'h1);
    checkOutput("single_busy", busy, 32'h1);
    req[1] = 1'b0;
    @(negedge clock);
    checkOutput("single_gnt_pulse", gnt, 32'h0);
    checkOutput("single_start_drop", m_start, 32'h0);
    waitResponse(v);
    checkOutput("single_rsp", v, 32'h2);
    checkOutput("single_err", rsp_err, 32'h0);
    checkOutput("single_data", rsp_data, 32'h00);
    @(negedge clock);
    checkOutput("single_rsp_pulse", rsp_valid, 32'h0);
    checkOutput("single_gap_busy", busy, 32'h0);

    // Receive from requester 0.
    model_rx = 8'h3C;
    applyStimulus(0, 1'b1, 8'h77, 2'b10);
    waitGrant(g);
    checkOutput("rx_gnt", g, 32'h1);
    checkOutput("rx_we_gnt", m_write_enable, 32'h1);
    req[0] = 1'b0;
    waitResponse(v);
    checkOutput("rx_rsp", v, 32'h1);
    checkOutput("rx_data", rsp_data, 32'h3C);
    checkOutput("rx_err", rsp_err, 32'h0);
    checkOutput("rx_we_rsp", m_write_enable, 32'h1);

    // Round robin from reset with all four requesting.
    applyReset();
    req_we = '0; req_data = 32'h44332211; req_div = 8'b11_10_01_00;
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      e = i % 4;
      waitGrant(g);
      checkOutput("rr_gnt", g, 32'(1) << e);
      checkOutput("rr_tx", m_data_tx, rr_bytes[e]);
      checkOutput("rr_div", m_clock_div, e);
      if (i == 4) req = '0;
      waitResponse(v);
      checkOutput("rr_rsp", v, 32'(1) << e);
    end

    // Timeout in START with done stuck high.
    model_mode = 0;
    applyStimulus(2, 1'b1, 8'h5A, 2'b00);
    waitGrant(g);
    checkOutput("tmo_gnt", g, 32'h4);
    req[2] = 1'b0;
    n = 0;
    while (m_start && n < 100) begin
      n++;
      @(negedge clock);
    end
    checkOutput("tmo_start_cycles", n, TMO);
    checkOutput("tmo_rsp", rsp_valid, 32'h4);
    checkOutput("tmo_err", rsp_err, 32'h1);
    checkOutput("tmo_data", rsp_data, 32'h00);
    model_mode = 1;
    applyStimulus(3, 1'b0, 8'h99, 2'b01);
    waitGrant(g);
    checkOutput("tmo_next_gnt", g, 32'h8);
    req[3] = 1'b0;
    waitResponse(v);
    checkOutput("tmo_next_rsp", v, 32'h8);
    checkOutput("tmo_next_err", rsp_err, 32'h0);

    // Reset while BUSY: outputs clear at once and no response appears.
    model_latency = 20;
    applyStimulus(1, 1'b0, 8'hC3, 2'b10);
    waitGrant(g);
    checkOutput("rst_gnt", g, 32'h2);
    req[1] = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_busy_before", busy, 32'h1);
    applyStimulus(2, 1'b0, 8'h5F, 2'b11);
    reset = 1'b1;
    #1;
    checkOutput("rst_outputs", {gnt, rsp_valid, rsp_err, rsp_data, busy,
                m_start, m_write_enable, m_data_tx, m_clock_div}, 32'h0);
    rsp_seen = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      rsp_seen |= rsp_valid;
    end
    reset = 1'b0;
    model_latency = 3;
    checkOutput("rst_no_rsp", rsp_seen, 32'h0);
    waitGrant(g);
    checkOutput("rst_after_gnt", g, 32'h4);
    checkOutput("rst_after_tx", m_data_tx, 32'h5F);
    checkOutput("rst_after_div", m_clock_div, 32'h3);
    req[2] = 1'b0;
    waitResponse(v);
    checkOutput("rst_after_rsp", v, 32'h4);

    // Operand stability after grant.
    model_latency = 5;
    applyStimulus(0, 1'b0, 8'h11, 2'b01);
    waitGrant(g);
    checkOutput("stab_gnt", g, 32'h1);
    req[0] = 1'b0;
    @(negedge clock);
    req_data[7:0] = 8'h22;
    bad = 8'h11;
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      if (m_data_tx != 8'h11) bad = m_data_tx;
      @(negedge clock);
      n++;
    end
    checkOutput("stab_tx", bad, 32'h11);
    checkOutput("stab_rsp", rsp_valid, 32'h1);
    checkOutput("stab_tx_rsp", m_data_tx, 32'h11);

    checkOutput("gnt_rsp_overlap", overlap, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
